// File: rtl/pcw_tick_timer.sv
// pcw_tick_timer
//   Divides the 4 MHz clock-enable strobe down to the 300 Hz system tick,
//   keeps a saturating tick count that the CPU reads and clears through a
//   port strobe, drives the timer interrupt request, and watches the enable
//   stream for a stalled generator.
//
// Parameters
//   CE_DIV     : ce_4mhz pulses per tick (2..16383)
//   CE_TIMEOUT : clk cycles without ce_4mhz before ce_lost asserts (17..255)
//
// Ports
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   ce_4mhz   : clock-enable strobe, one pulse per high cycle
//   rd_strobe : one-cycle CPU read of the tick count
//   int_en    : timer interrupt enable level
//   rd_data   : {overflow, count[3:0]} snapshot taken by rd_strobe
//   tick      : one-cycle pulse per tick period
//   int_req   : timer interrupt request level
//   ce_lost   : enable-stream watchdog flag
module pcw_tick_timer #(
  parameter int CE_DIV     = 13333,
  parameter int CE_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_4mhz,
  input  logic       rd_strobe,
  input  logic       int_en,
  output logic [4:0] rd_data,
  output logic       tick,
  output logic       int_req,
  output logic       ce_lost
);

  localparam logic [13:0] DIV_LAST = 14'(CE_DIV - 1);
  localparam logic [7:0]  TO_M1    = 8'(CE_TIMEOUT - 1);

  logic [13:0] r_pre;
  logic [7:0]  r_wd;
  logic [3:0]  r_cnt;
  logic        r_ovf;
  logic        r_tick;
  logic        r_int;
  logic        r_lost;
  logic [4:0]  r_rd;

  logic w_wrap;
  logic w_timeout;

  // Pulse that completes the current prescaler period.
  assign w_wrap    = ce_4mhz && (r_pre == DIV_LAST);
  // Watchdog reaches CE_TIMEOUT at this edge (counter is one below it now).
  assign w_timeout = !ce_4mhz && (r_wd >= TO_M1);

  // Prescaler and enable-stream watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre  <= '0;
      r_wd   <= '0;
      r_lost <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (ce_4mhz) begin
        r_wd   <= '0;
        r_lost <= 1'b0;
        r_pre  <= w_wrap ? 14'd0 : r_pre + 14'd1;
      end else begin
        if (r_wd != 8'hFF) r_wd <= r_wd + 8'd1;
        // A stalled stream discards the partial period, so the first pulse
        // after recovery starts a fresh one.
        if (w_timeout) begin
          r_lost <= 1'b1;
          r_pre  <= '0;
        end
      end
    end
  end

  // Saturating tick count, sticky overflow and read snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_rd  <= '0;
    end else if (rd_strobe) begin
      // Snapshot uses pre-update values; a coincident tick is carried into
      // the freshly cleared count rather than lost.
      r_rd  <= {r_ovf, r_cnt};
      r_cnt <= w_wrap ? 4'd1 : 4'd0;
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      if (r_cnt == 4'hF) r_ovf <= 1'b1;
      else               r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_int <= 1'b0;
    else          r_int <= int_en && (r_cnt != 4'd0);
  end

  assign rd_data = r_rd;
  assign tick    = r_tick;
  assign int_req = r_int;
  assign ce_lost = r_lost;

endmodule

// File: tb/tb_pcw_tick_timer.sv
module tb_pcw_tick_timer;

  localparam int DIV = 4;
  localparam int TO  = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ce_4mhz = 1'b0;
  logic       rd_strobe = 1'b0;
  logic       int_en = 1'b0;
  logic [4:0] rd_data;
  logic       tick;
  logic       int_req;
  logic       ce_lost;

  pcw_tick_timer #(.CE_DIV(DIV), .CE_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ce_4mhz(ce_4mhz), .rd_strobe(rd_strobe),
    .int_en(int_en), .rd_data(rd_data), .tick(tick), .int_req(int_req),
    .ce_lost(ce_lost)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pulses within the current period, unsaturated ticks
  // since the last read, consecutive cycles without an enable pulse.
  int         m_pulses = 0;
  int         m_ticks  = 0;
  int         m_idle   = 0;
  logic [4:0] e_rd   = '0;
  logic       e_tick = 1'b0;
  logic       e_int  = 1'b0;
  logic       e_lost = 1'b0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_pulses = 0; m_ticks = 0; m_idle = 0;
      e_rd = '0; e_tick = 1'b0; e_int = 1'b0; e_lost = 1'b0;
    end else begin
      int t;
      t = 0;
      e_int = int_en && (m_ticks != 0);
      if (ce_4mhz) begin
        m_pulses++;
        if (m_pulses == DIV) begin t = 1; m_pulses = 0; end
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TO) m_pulses = 0;
      end
      if (rd_strobe) begin
        e_rd = {m_ticks >= 16, (m_ticks >= 15) ? 4'hF : 4'(m_ticks)};
        m_ticks = t;
      end else begin
        m_ticks += t;
      end
      e_tick = (t != 0);
      e_lost = (m_idle >= TO);
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("tick",    32'(tick),    32'(e_tick));
    chk("rd_data", 32'(rd_data), 32'(e_rd));
    chk("int_req", 32'(int_req), 32'(e_int));
    chk("ce_lost", 32'(ce_lost), 32'(e_lost));
  end

  int cyc = 0;
  int tick_cnt = 0;
  int last_tick = -1;
  logic chk_spacing = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (tick) begin
      tick_cnt++;
      if (chk_spacing && last_tick >= 0) chk("tick_spacing", 32'(cyc - last_tick), 32'd64);
      last_tick = cyc;
    end
  end

  task automatic cyc1(input logic c, input logic r);
    ce_4mhz = c;
    rd_strobe = r;
    @(posedge clk);
    #1;
    ce_4mhz = 1'b0;
    rd_strobe = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      cyc1(1'b1, 1'b0);
      repeat (15) cyc1(1'b0, 1'b0);
    end
  endtask

  initial begin
    int k;
    int t0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Nominal enable spacing, interrupts disabled.
    chk_spacing = 1'b1;
    pulses(12);
    chk_spacing = 1'b0;
    chk("int_off", 32'(int_req), 32'd0);
    cyc1(1'b0, 1'b1);
    chk("rd_cnt3", 32'(rd_data), 32'h03);

    // Two ticks with interrupts enabled, then read.
    int_en = 1'b1;
    pulses(8);
    chk("int_on", 32'(int_req), 32'd1);
    cyc1(1'b0, 1'b1);
    chk("rd_cnt2", 32'(rd_data), 32'h02);
    chk("int_hold", 32'(int_req), 32'd1);
    cyc1(1'b0, 1'b0);
    chk("int_fall", 32'(int_req), 32'd0);

    // Overflow, then back-to-back read.
    pulses(68);
    cyc1(1'b0, 1'b1);
    chk("rd_ovf", 32'(rd_data), 32'h1F);
    cyc1(1'b0, 1'b1);
    chk("rd_b2b", 32'(rd_data), 32'h00);

    // Read coincident with the tick-producing pulse.
    pulses(8);
    pulses(3);
    cyc1(1'b1, 1'b1);
    chk("rd_coinc", 32'(rd_data), 32'h02);
    chk("tick_coinc", 32'(tick), 32'd1);
    repeat (15) cyc1(1'b0, 1'b0);
    cyc1(1'b0, 1'b1);
    chk("rd_carry", 32'(rd_data), 32'h01);

    // Watchdog: stop after two pulses of a period.
    cyc1(1'b1, 1'b0);
    repeat (15) cyc1(1'b0, 1'b0);
    cyc1(1'b1, 1'b0);
    k = 1;
    while (!ce_lost && k < 100) begin
      cyc1(1'b0, 1'b0);
      k++;
    end
    chk("lost_delay", 32'(k), 32'd33);
    cyc1(1'b1, 1'b0);
    chk("lost_clear", 32'(ce_lost), 32'd0);
    t0 = tick_cnt;
    repeat (15) cyc1(1'b0, 1'b0);
    pulses(2);
    chk("no_early_tick", 32'(tick_cnt - t0), 32'd0);
    cyc1(1'b1, 1'b0);
    chk("fresh_tick", 32'(tick), 32'd1);

    // Asynchronous reset mid-period.
    repeat (15) cyc1(1'b0, 1'b0);
    cyc1(1'b0, 1'b1);
    chk("rd_pre_rst", 32'(rd_data), 32'h01);
    pulses(28);
    chk("int_cnt7", 32'(int_req), 32'd1);
    cyc1(1'b1, 1'b0);
    repeat (15) cyc1(1'b0, 1'b0);
    cyc1(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rd",   32'(rd_data), 32'd0);
    chk("rst_tick", 32'(tick),    32'd0);
    chk("rst_int",  32'(int_req), 32'd0);
    chk("rst_lost", 32'(ce_lost), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    t0 = tick_cnt;
    pulses(3);
    chk("rst_no_tick", 32'(tick_cnt - t0), 32'd0);
    cyc1(1'b1, 1'b0);
    chk("rst_full_period", 32'(tick), 32'd1);

    // Randomized traffic with occasional stalls.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 50 == 0) int_en = ~int_en;
      if ($urandom % 200 == 0) begin
        repeat ($urandom_range(20, 45)) cyc1(1'b0, ($urandom % 25) == 0);
      end else begin
        cyc1(($urandom % 8) == 0, ($urandom % 25) == 0);
      end
    end

    repeat (3) cyc1(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pcw_tick_timer.md
# pcw_tick_timer

Consumer end of the PCW clock-enable fabric. It takes the 4 MHz clock-enable strobe and divides it into the 300 Hz system tick. It keeps a saturating tick count that the CPU reads through a port strobe, and raises the timer interrupt request. A watchdog flags loss of the enable stream so the rest of the machine can detect a stalled generator.

## Interface
Parameters:
- CE_DIV, 13333, number of ce_4mhz pulses per tick (4 MHz / 13333 ≈ 300 Hz); legal range 2..16383.
- CE_TIMEOUT, 32, number of clk cycles without ce_4mhz after which ce_lost asserts; legal range 17..255.

Ports:
- clk, in, 1, system clock (64 MHz; ce_4mhz nominally every 16 cycles).
- reset_n, in, 1, asynchronous active-low reset; one clock, no other clock domains.
- ce_4mhz, in, 1, clock-enable strobe; sampled every clk, each high cycle counts as one pulse.
- rd_strobe, in, 1, one-cycle CPU read of the tick count port.
- int_en, in, 1, timer interrupt enable level.
- rd_data, out, 5, {overflow, count[3:0]} snapshot captured by rd_strobe.
- tick, out, 1, one-cycle pulse per 300 Hz period.
- int_req, out, 1, timer interrupt request level.
- ce_lost, out, 1, enable-stream watchdog flag.

## Operation
- Prescaler: 14-bit counter.
  - Increments on each clk with ce_4mhz=1.
  - On a pulse while at CE_DIV-1 it wraps to 0 and tick is registered high for the next cycle.
- Tick count: 4-bit, +1 per tick, saturating at 15.
  - A tick arriving while count=15 sets the sticky overflow bit.
- Read (rd_strobe=1 in cycle N):
  - rd_data <= {overflow, count}, using the pre-update values of cycle N.
  - count and overflow are cleared.
  - rd_data holds its value until the next rd_strobe.
- Simultaneous tick and rd_strobe in the same cycle:
  - The snapshot excludes that tick.
  - count becomes 1 and overflow becomes 0.
  - The tick is never lost.
- int_req: registered as int_en & (count != 0).
  - Deasserting int_en or reading the count drops int_req one cycle later.
- Watchdog: 8-bit counter of clk cycles since the last ce_4mhz.
  - Cleared on every ce_4mhz; saturates.
  - When it reaches CE_TIMEOUT, ce_lost is set and the prescaler is forced to 0.
  - ce_lost clears in the cycle after the next ce_4mhz. That pulse counts as prescaler pulse 1 of a fresh period.
- Reset mid-operation: all state clears immediately. Any partial prescaler period is discarded and no tick is generated for it.

## Timing
- Reset values: rd_data=0, tick=0, int_req=0, ce_lost=0. Prescaler, count, overflow and watchdog counter all reset to 0.
- Tick latency: a ce_4mhz pulse in cycle N that completes the period gives tick=1 in N+1 only. The updated count is visible in N+1; int_req rises in N+2.
- With a nominal 16-cycle ce_4mhz spacing the tick period is CE_DIV*16 clk cycles exactly, with no drift.
- Read latency: rd_data is valid in N+1 after rd_strobe in N. Cleared count is visible in N+1; int_req falls in N+2.
- ce_lost timing: with the last ce_4mhz in cycle M, ce_lost rises in cycle M+CE_TIMEOUT+1.
- A back-to-back rd_strobe (N and N+1) returns the N snapshot first, then {0,0} unless a tick landed between.

## Test plan
- Reset, then CE_DIV=4 with ce_4mhz every 16 clk: tick pulses exactly every 64 clk, one cycle wide; count reaches 3 after 3 ticks; int_req stays 0 with int_en=0.
- Set int_en=1, wait for 2 ticks, then pulse rd_strobe: rd_data=5'b0_0010 next cycle; count=0 and int_req falls 2 cycles after the strobe.
- Run 17 ticks without a read, then read: rd_data=5'b1_1111; a second read returns 5'b0_0000.
- Place rd_strobe in the same cycle the tick-producing ce_4mhz is registered, with count=2: rd_data=5'b0_0010 and count=1 afterwards, so no tick is lost.
- Stop ce_4mhz after prescaler=2 with CE_TIMEOUT=32: ce_lost rises 33 cycles after the last pulse. Resume pulses: ce_lost clears after the first pulse, and the first tick arrives after 4 pulses, not 2.
- Assert reset_n low asynchronously mid-period with count=7 and int_req=1: all outputs drop to 0 without a clock edge. After release the first tick needs a full CE_DIV pulses.
